fir_sample_capture: RTL and testbench

Capture buffer sitting downstream of the FIR filter output stream (valid-qualified signed 16-bit samples). It is software-armed and waits for a trigger condition on the sample stream. It then records exactly DEPTH consecutive valid samples into an on-chip RAM. Once complete, it holds the record for in-order readout by the HPS-side CSR/bridge logic.

---
 rtl/fir_sample_capture.sv | 189 ++++++++++++++++++
 tb/tb_fir_sample_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_capture.sv
// fir_sample_capture
//   Software-armed capture buffer on the FIR output stream. After arm, it
//   waits for a trigger on the valid-qualified sample stream. It then stores
//   exactly DEPTH consecutive valid samples into on-chip RAM. The record is
//   frozen for in-order, wrapping readout.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              low forces IDLE and clears all control state
//   arm                 single-cycle pulse, starts a new capture
//   trig_mode[1:0]      0/3 immediate, 1 rising crossing, 2 falling crossing
//   threshold[15:0]     signed trigger level
//   sample_valid        sample qualifier
//   sample[15:0]        signed sample
//   rd_en               read strobe (honoured only in DONE)
//   rd_data[15:0]       signed read data, valid one cycle after rd_en
//   rd_valid            rd_data qualifier
//   busy                ARMED or CAPTURE
//   done                DONE
//   count[AW:0]         samples stored in the current record
module fir_sample_capture #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic signed [15:0] threshold,
  input  logic               sample_valid,
  input  logic signed [15:0] sample,
  input  logic               rd_en,
  output logic signed [15:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic signed [15:0] prev_q, prev_d;
  logic               prev_ok_q, prev_ok_d;
  logic               rd_valid_q, rd_valid_d;
  logic signed [15:0] rd_data_q;

  logic               trig_hit;
  logic               wr_en;
  logic               rd_fire;

  logic signed [15:0] mem [DEPTH];

  // Crossing modes need a previous sample from this arm; the first valid
  // sample after arm can only seed prev, never fire a crossing trigger.
  always_comb begin
    case (trig_mode)
      2'd1:    trig_hit = prev_ok_q && (prev_q < threshold) && (sample >= threshold);
      2'd2:    trig_hit = prev_ok_q && (prev_q > threshold) && (sample <= threshold);
      default: trig_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    prev_d     = prev_q;
    prev_ok_d  = prev_ok_q;
    wr_en      = 1'b0;
    rd_fire    = 1'b0;

    if (!enable) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      prev_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d   = S_ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            prev_ok_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (sample_valid) begin
            prev_d    = sample;
            prev_ok_d = 1'b1;
            if (trig_hit) begin
              // wr_ptr_q is 0 here, so the triggering sample lands at address 0
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              count_d  = (AW+1)'(1);
              state_d  = (DEPTH_C == (AW+1)'(1)) ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
            if (count_q == DEPTH_C - (AW+1)'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          // arm wins over a coincident rd_en; that read is dropped
          if (arm) begin
            state_d   = S_ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            prev_ok_d = 1'b0;
          end else if (rd_en) begin
            rd_fire  = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    rd_valid_d = rd_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_q     <= prev_d;
      prev_ok_q  <= prev_ok_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Sample RAM: write port has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= sample;
    end
  end

  // Synchronous read port; output register is cleared by reset and disable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (!enable) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign count    = count_q;

endmodule

// File: tb/tb_fir_sample_capture.sv
module tb_fir_sample_capture;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               arm;
  logic [1:0]         trig_mode;
  logic signed [15:0] threshold;
  logic               sample_valid;
  logic signed [15:0] sample;
  logic               rd_en;
  logic signed [15:0] rd_data;
  logic               rd_valid;
  logic               busy;
  logic               done;
  logic [AW:0]        count;

  always #5 clk = ~clk;

  fir_sample_capture #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .arm          (arm),
    .trig_mode    (trig_mode),
    .threshold    (threshold),
    .sample_valid (sample_valid),
    .sample       (sample),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .done         (done),
    .count        (count)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic signed [15:0] d;
    int                 due;
  } exp_t;
  exp_t exp_q[$];

  localparam logic signed [15:0] RISE [12] =
    '{16'sd200, -16'sd50, 16'sd50, 16'sd99, 16'sd100, 16'sd150,
      16'sd160, 16'sd170, 16'sd180, 16'sd190, 16'sd200, 16'sd210};
  localparam logic signed [15:0] FALL [12] =
    '{-16'sd2000, -16'sd1500, 16'sd0, -16'sd999, -16'sd1000, -16'sd1001,
      -16'sd1002, -16'sd1003, -16'sd1004, -16'sd1005, -16'sd1006, -16'sd1007};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read result is due exactly one cycle after its rd_en;
  // in all other cycles rd_valid must be low.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, e.d);
      end else begin
        check("rd_valid_idle", rd_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic v, input logic signed [15:0] s,
                       input logic r);
    arm          = a;
    sample_valid = v;
    sample       = s;
    rd_en        = r;
    tick();
    arm          = 1'b0;
    sample_valid = 1'b0;
    rd_en        = 1'b0;
  endtask

  task automatic read_exp(input logic signed [15:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + 1;
    exp_q.push_back(e);
    drive(1'b0, 1'b0, 16'sd0, 1'b1);
  endtask

  task automatic status(input string name, input logic b, input logic dn, input int c);
    check({name, "_busy"}, busy, b);
    check({name, "_done"}, done, dn);
    check({name, "_count"}, count, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; arm = 1'b0; trig_mode = 2'd0; threshold = 16'sd0;
    sample_valid = 1'b0; sample = 16'sd0; rd_en = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    status("reset", 1'b0, 1'b0, 0);
    check("reset_rd_data", rd_data, 0);

    // Immediate capture, samples every other cycle, then wrap read
    trig_mode = 2'd0;
    drive(1'b1, 1'b0, 16'sd0, 1'b0);
    status("imm_arm", 1'b1, 1'b0, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1, 16'(i), 1'b0);
      if (i == 7) status("imm7", 1'b1, 1'b0, 7);
      if (i == 8) status("imm8", 1'b0, 1'b1, 8);
      drive(1'b0, 1'b0, 16'sd0, 1'b0);
    end
    status("imm_end", 1'b0, 1'b1, 8);
    for (int i = 1; i <= 8; i++) read_exp(16'(i));
    read_exp(16'sd1);
    drive(1'b0, 1'b0, 16'sd0, 1'b0);

    // Rising crossing at 100; leading 200 must not trigger
    trig_mode = 2'd1;
    threshold = 16'sd100;
    drive(1'b1, 1'b0, 16'sd0, 1'b0);
    status("rise_arm", 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, RISE[i], 1'b0);
      if (i == 0) status("rise_first", 1'b1, 1'b0, 0);
      if (i == 3) status("rise_pre", 1'b1, 1'b0, 0);
      if (i == 4) status("rise_trig", 1'b1, 1'b0, 1);
    end
    status("rise_done", 1'b0, 1'b1, 8);
    for (int i = 4; i < 12; i++) read_exp(RISE[i]);
    drive(1'b0, 1'b0, 16'sd0, 1'b0);

    // Falling crossing at -1000
    trig_mode = 2'd2;
    threshold = -16'sd1000;
    drive(1'b1, 1'b0, 16'sd0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, FALL[i], 1'b0);
      if (i == 1) status("fall_neg", 1'b1, 1'b0, 0);
      if (i == 3) status("fall_pre", 1'b1, 1'b0, 0);
      if (i == 4) status("fall_trig", 1'b1, 1'b0, 1);
    end
    status("fall_done", 1'b0, 1'b1, 8);
    for (int i = 4; i < 12; i++) read_exp(FALL[i]);

    // Samples during DONE leave the record unchanged
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'sd5555, 1'b0);
    status("done_hold", 1'b0, 1'b1, 8);
    for (int i = 4; i < 12; i++) read_exp(FALL[i]);

    // arm + rd_en together: arm wins, read dropped; rd_en while busy ignored
    drive(1'b1, 1'b0, 16'sd0, 1'b1);
    status("prio", 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 16'sd0, 1'b1);
    status("rd_busy", 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 16'sd0, 1'b0);

    // Abort mid-capture, arm ignored during capture, then fresh capture
    trig_mode = 2'd0;
    drive(1'b0, 1'b1, 16'sd1, 1'b0);
    status("ab1", 1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 16'sd2, 1'b0);
    drive(1'b0, 1'b1, 16'sd3, 1'b0);
    drive(1'b1, 1'b1, 16'sd4, 1'b0);
    status("arm_ign", 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 16'sd5, 1'b0);
    status("ab5", 1'b1, 1'b0, 5);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    status("abort", 1'b0, 1'b0, 0);
    check("abort_rd_data", rd_data, 0);
    drive(1'b0, 1'b1, 16'sd9, 1'b0);
    status("idle_stay", 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 16'sd0, 1'b0);
    for (int i = 20; i < 28; i++) drive(1'b0, 1'b1, 16'(i), 1'b0);
    status("fresh_done", 1'b0, 1'b1, 8);
    for (int i = 20; i < 28; i++) read_exp(16'(i));

    drive(1'b0, 1'b0, 16'sd0, 1'b0);
    drive(1'b0, 1'b0, 16'sd0, 1'b0);
    check("pending_reads", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
